// File: rtl/sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sdram_arbiter
// Purpose  : Three-port arbiter (video DMA, sound DMA, CPU) for a 32-bit
//            SDRAM controller port. Fixed priority vid > snd > cpu, with a
//            starvation override that promotes the CPU after STARVE_LIMIT
//            waiting cycles. One transaction is in flight at a time; per-word
//            acks and read data are routed back to the granted requester and
//            a stalled transaction is aborted after TIMEOUT cycles.
// Ports    : sd_clk, sd_rst           clock, asynchronous active-high reset
//            vid_/snd_/cpu_req,_adr   requests and byte addresses
//            cpu_we/_sel/_dat_i/_burst CPU write, byte enables, data, burst
//            vid_/snd_/cpu_ack        per-word ack pulses to requesters
//            port_dat_o               read data shared by all requesters
//            cpu_err                  pulse on timeout abort
//            mem_*                    controller request side
// Revision : 1.0 - initial release
// ============================================================================
module sdram_arbiter #(
   parameter int STARVE_LIMIT = 32,
   parameter int TIMEOUT      = 255,
   parameter int BURST_LEN    = 4
) (
   input  logic        sd_clk,
   input  logic        sd_rst,
   input  logic        vid_req,
   input  logic [23:0] vid_adr,
   input  logic        snd_req,
   input  logic [23:0] snd_adr,
   input  logic        cpu_req,
   input  logic [23:0] cpu_adr,
   input  logic        cpu_we,
   input  logic [3:0]  cpu_sel,
   input  logic [31:0] cpu_dat_i,
   input  logic        cpu_burst,
   output logic        vid_ack,
   output logic        snd_ack,
   output logic        cpu_ack,
   output logic [31:0] port_dat_o,
   output logic        cpu_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic        mem_burst,
   output logic [23:0] mem_adr,
   output logic [3:0]  mem_sel,
   output logic [31:0] mem_dat_o,
   input  logic        mem_ack,
   input  logic [31:0] mem_dat_i
);

   localparam int              WL_W       = $clog2(BURST_LEN + 1);
   localparam logic [WL_W-1:0] WL_BURST   = WL_W'(BURST_LEN);
   localparam logic [WL_W-1:0] WL_ONE     = WL_W'(1);
   localparam logic [7:0]      STARVE_THR = 8'(STARVE_LIMIT);
   localparam logic [7:0]      TMO_LAST   = 8'(TIMEOUT - 1);
   localparam logic [23:0]     ADR_MASK   = 24'hFF_FFFC;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t          state, state_nxt;
   logic [2:0]      grant;        // one-hot: [0] vid, [1] snd, [2] cpu
   logic [WL_W-1:0] words_left;
   logic [7:0]      starve_cnt;
   logic [7:0]      tmo_cnt;

   // Arbitration result and the fields of the winning requester
   logic [2:0]  pick;
   logic        take;
   logic        pick_we, pick_burst;
   logic [23:0] pick_adr;
   logic [3:0]  pick_sel;
   logic [31:0] pick_dat;

   // FSM event decodes
   logic word_ack, last_word, abort;

   always_comb begin
      pick = 3'b000;
      if (cpu_req && (starve_cnt >= STARVE_THR)) pick = 3'b100;
      else if (vid_req)                          pick = 3'b001;
      else if (snd_req)                          pick = 3'b010;
      else if (cpu_req)                          pick = 3'b100;

      take       = (state == ST_IDLE) && (pick != 3'b000);
      pick_we    = pick[2] & cpu_we;
      // Video and sound always burst; a CPU write never bursts.
      pick_burst = ~pick[2] | (cpu_burst & ~cpu_we);
      pick_adr   = pick[0] ? vid_adr : (pick[1] ? snd_adr : cpu_adr);
      pick_sel   = pick[2] ? cpu_sel   : 4'hF;
      pick_dat   = pick[2] ? cpu_dat_i : 32'h0;
   end

   always_ff @(posedge sd_clk or posedge sd_rst) begin
      if (sd_rst) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      word_ack  = 1'b0;
      last_word = 1'b0;
      abort     = 1'b0;
      case (state)
         ST_IDLE:  if (take) state_nxt = ST_ISSUE;
         ST_ISSUE: state_nxt = ST_WAIT;
         ST_WAIT: begin
            // An ack arriving on the timeout cycle takes precedence.
            if (mem_ack) begin
               word_ack = 1'b1;
               if (words_left == WL_ONE) begin
                  last_word = 1'b1;
                  state_nxt = ST_DONE;
               end
            end else if (tmo_cnt >= TMO_LAST) begin
               abort     = 1'b1;
               state_nxt = ST_DONE;
            end
         end
         // DONE is a dead cycle so the finishing port can drop its request.
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge sd_clk or posedge sd_rst) begin
      if (sd_rst) begin
         grant      <= 3'b000;
         words_left <= '0;
         starve_cnt <= 8'd0;
         tmo_cnt    <= 8'd0;
         vid_ack    <= 1'b0;
         snd_ack    <= 1'b0;
         cpu_ack    <= 1'b0;
         port_dat_o <= 32'h0;
         cpu_err    <= 1'b0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_burst  <= 1'b0;
         mem_adr    <= 24'h0;
         mem_sel    <= 4'h0;
         mem_dat_o  <= 32'h0;
      end else begin
         vid_ack <= 1'b0;
         snd_ack <= 1'b0;
         cpu_ack <= 1'b0;
         cpu_err <= 1'b0;

         if (take) begin
            grant      <= pick;
            mem_req    <= 1'b1;
            mem_we     <= pick_we;
            mem_burst  <= pick_burst;
            mem_adr    <= pick_adr & ADR_MASK;
            mem_sel    <= pick_sel;
            mem_dat_o  <= pick_dat;
            words_left <= pick_burst ? WL_BURST : WL_ONE;
            tmo_cnt    <= 8'd0;
         end

         if ((state == ST_WAIT) && (tmo_cnt != 8'hFF))
            tmo_cnt <= tmo_cnt + 8'd1;

         if (word_ack) begin
            port_dat_o                  <= mem_dat_i;
            {cpu_ack, snd_ack, vid_ack} <= grant;
            words_left                  <= words_left - WL_ONE;
         end

         if (abort) begin
            port_dat_o                  <= 32'h0;
            {cpu_ack, snd_ack, vid_ack} <= grant;
            cpu_err                     <= 1'b1;
         end

         if (last_word || abort) mem_req <= 1'b0;

         if (state == ST_DONE) grant <= 3'b000;

         if (take && pick[2])
            starve_cnt <= 8'd0;
         else if (cpu_req && !grant[2] && (starve_cnt != 8'hFF))
            starve_cnt <= starve_cnt + 8'd1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_arbiter
// Purpose  : Self-checking bench for sdram_arbiter. A responder plays the
//            SDRAM controller; a cycle-level reference model built from the
//            arbitration/timing rules predicts grants, acks, data and errors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_arbiter;

   localparam int STARVE_LIMIT = 32;
   localparam int TIMEOUT      = 255;
   localparam int BURST_LEN    = 4;

   logic        sd_clk = 1'b0;
   logic        sd_rst = 1'b1;
   logic        vid_req = 1'b0, snd_req = 1'b0, cpu_req = 1'b0;
   logic [23:0] vid_adr = 24'h0, snd_adr = 24'h0, cpu_adr = 24'h0;
   logic        cpu_we = 1'b0, cpu_burst = 1'b0;
   logic [3:0]  cpu_sel = 4'hF;
   logic [31:0] cpu_dat_i = 32'h0;
   logic        vid_ack, snd_ack, cpu_ack, cpu_err;
   logic [31:0] port_dat_o;
   logic        mem_req, mem_we, mem_burst;
   logic [23:0] mem_adr;
   logic [3:0]  mem_sel;
   logic [31:0] mem_dat_o;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_dat_i = 32'h0;

   int checks = 0;
   int errors = 0;
   int cyc_cnt = 0;

   sdram_arbiter #(
      .STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT), .BURST_LEN(BURST_LEN)
   ) dut (
      .sd_clk(sd_clk), .sd_rst(sd_rst),
      .vid_req(vid_req), .vid_adr(vid_adr),
      .snd_req(snd_req), .snd_adr(snd_adr),
      .cpu_req(cpu_req), .cpu_adr(cpu_adr),
      .cpu_we(cpu_we), .cpu_sel(cpu_sel), .cpu_dat_i(cpu_dat_i), .cpu_burst(cpu_burst),
      .vid_ack(vid_ack), .snd_ack(snd_ack), .cpu_ack(cpu_ack),
      .port_dat_o(port_dat_o), .cpu_err(cpu_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_burst(mem_burst),
      .mem_adr(mem_adr), .mem_sel(mem_sel), .mem_dat_o(mem_dat_o),
      .mem_ack(mem_ack), .mem_dat_i(mem_dat_i)
   );

   initial forever #5 sd_clk = ~sd_clk;
   always @(posedge sd_clk) cyc_cnt <= cyc_cnt + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, got running exp finished");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------- responder
   int   lat_max   = 2;
   bit   no_ack    = 1'b0;
   int   fixed_lat = -1;
   logic [31:0] fixed_dat = 32'h0;
   int   lat_cnt   = 0;
   bit   prev_req  = 1'b0;

   always begin
      @(posedge sd_clk);
      #1;
      mem_ack = 1'b0;
      if (sd_rst) begin
         prev_req = 1'b0;
         lat_cnt  = 0;
      end else begin
         if (mem_req && !prev_req) begin
            if (fixed_lat >= 0) lat_cnt = fixed_lat;
            else                lat_cnt = $urandom_range(lat_max - 1, 0);
         end else if (mem_req && !no_ack) begin
            if (lat_cnt == 0) begin
               mem_ack = 1'b1;
               if (fixed_lat >= 0) begin
                  mem_dat_i = fixed_dat;
                  lat_cnt   = fixed_lat;
               end else begin
                  mem_dat_i = $urandom;
                  lat_cnt   = $urandom_range(lat_max - 1, 0);
               end
            end else begin
               lat_cnt--;
            end
         end
         prev_req = mem_req;
      end
   end

   // ---------------------------------------------------------- reference model
   localparam int M_FREE = 0, M_ISSUE = 1, M_WAIT = 2, M_DONE = 3;
   int          m_stage = M_FREE;
   int          m_own = -1;
   int          m_words = 0, m_wait = 0, m_starve = 0;
   bit          e_req = 1'b0, e_err = 1'b0, e_we = 1'b0, e_burst = 1'b0;
   logic [2:0]  e_ack = 3'b000;
   logic [31:0] e_dat = 32'h0, e_wdat = 32'h0;
   logic [23:0] e_adr = 24'h0;
   logic [3:0]  e_sel = 4'h0;

   always @(negedge sd_clk) begin
      bit cpu_waiting, granted_cpu;
      int g;
      if (sd_rst) begin
         m_stage = M_FREE; m_own = -1; m_words = 0; m_wait = 0; m_starve = 0;
         e_req = 1'b0; e_err = 1'b0; e_ack = 3'b000;
      end else begin
         checks++;
         if ({cpu_ack, snd_ack, vid_ack} !== e_ack) begin
            errors++;
            $display("FAIL mon_ack t=%0t got=%b exp=%b", $time, {cpu_ack, snd_ack, vid_ack}, e_ack);
         end
         if (e_ack != 3'b000) begin
            checks++;
            if (port_dat_o !== e_dat) begin
               errors++;
               $display("FAIL mon_data t=%0t got=%h exp=%h", $time, port_dat_o, e_dat);
            end
         end
         checks++;
         if (cpu_err !== e_err) begin
            errors++;
            $display("FAIL mon_err t=%0t got=%b exp=%b", $time, cpu_err, e_err);
         end
         checks++;
         if (mem_req !== e_req) begin
            errors++;
            $display("FAIL mon_mem_req t=%0t got=%b exp=%b", $time, mem_req, e_req);
         end
         if (e_req) begin
            checks++;
            if ({mem_we, mem_burst, mem_adr, mem_sel, mem_dat_o} !==
                {e_we, e_burst, e_adr, e_sel, e_wdat}) begin
               errors++;
               $display("FAIL mon_fields t=%0t got we=%b bu=%b a=%h s=%h d=%h exp we=%b bu=%b a=%h s=%h d=%h",
                        $time, mem_we, mem_burst, mem_adr, mem_sel, mem_dat_o,
                        e_we, e_burst, e_adr, e_sel, e_wdat);
            end
         end

         // Predict the next cycle from this cycle's inputs.
         cpu_waiting = cpu_req && (m_own != 2);
         granted_cpu = 1'b0;
         e_ack = 3'b000;
         e_err = 1'b0;
         case (m_stage)
            M_FREE: begin
               if (vid_req || snd_req || cpu_req) begin
                  if (cpu_req && m_starve >= STARVE_LIMIT) g = 2;
                  else if (vid_req)                       g = 0;
                  else if (snd_req)                       g = 1;
                  else                                    g = 2;
                  m_own   = g;
                  e_we    = (g == 2) && cpu_we;
                  e_burst = (g != 2) || (cpu_burst && !cpu_we);
                  e_adr   = ((g == 0) ? vid_adr : (g == 1) ? snd_adr : cpu_adr) & 24'hFF_FFFC;
                  e_sel   = (g == 2) ? cpu_sel : 4'hF;
                  e_wdat  = (g == 2) ? cpu_dat_i : 32'h0;
                  m_words = e_burst ? BURST_LEN : 1;
                  m_wait  = 0;
                  e_req   = 1'b1;
                  m_stage = M_ISSUE;
                  granted_cpu = (g == 2);
               end else begin
                  e_req = 1'b0;
               end
            end
            M_ISSUE: m_stage = M_WAIT;
            M_WAIT: begin
               m_wait++;
               if (mem_ack) begin
                  e_ack[m_own] = 1'b1;
                  e_dat = mem_dat_i;
                  m_words--;
                  if (m_words == 0) begin
                     e_req = 1'b0;
                     m_stage = M_DONE;
                  end
               end else if (m_wait >= TIMEOUT) begin
                  e_ack[m_own] = 1'b1;
                  e_dat = 32'h0;
                  e_err = 1'b1;
                  e_req = 1'b0;
                  m_stage = M_DONE;
               end
            end
            default: begin
               m_stage = M_FREE;
               m_own = -1;
            end
         endcase
         if (granted_cpu)                        m_starve = 0;
         else if (cpu_waiting && m_starve < 255) m_starve++;
      end
   end

   // ------------------------------------------------------------ requester util
   task automatic run_port(input int p, input int n, input int budget,
                           output int got, output int t_end);
      bit a;
      got = 0;
      t_end = -1;
      case (p)
         0: vid_req = 1'b1;
         1: snd_req = 1'b1;
         default: cpu_req = 1'b1;
      endcase
      for (int cyc = 0; cyc < budget && got < n; cyc++) begin
         @(posedge sd_clk);
         #1;
         a = (p == 0) ? vid_ack : (p == 1) ? snd_ack : cpu_ack;
         if (a) begin
            got++;
            if (got == n) t_end = cyc_cnt;
         end
      end
      case (p)
         0: vid_req = 1'b0;
         1: snd_req = 1'b0;
         default: cpu_req = 1'b0;
      endcase
   endtask

   // ------------------------------------------------------------------ tests
   task automatic test_reset();
      sd_rst = 1'b1;
      repeat (3) @(posedge sd_clk);
      #1;
      checks++;
      if ({vid_ack, snd_ack, cpu_ack, cpu_err, mem_req, mem_we, mem_burst} !== 7'b0 ||
          port_dat_o !== 32'h0 || {mem_adr, mem_sel, mem_dat_o} !== 60'h0) begin
         errors++;
         $display("FAIL reset_outputs got req=%b adr=%h dat=%h exp all zero", mem_req, mem_adr, port_dat_o);
      end
      checks++;
      if (dut.starve_cnt !== 8'd0) begin
         errors++;
         $display("FAIL reset_starve got=%0d exp=0", dut.starve_cnt);
      end
      sd_rst = 1'b0;
      repeat (2) @(posedge sd_clk);
      #1;
      checks++;
      if (mem_req !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle got mem_req=%b exp=0", mem_req);
      end
   endtask

   task automatic test_single_read();
      int got = 0;
      fixed_lat = 5;
      fixed_dat = 32'hDEAD_BEEF;
      cpu_adr = 24'h000100; cpu_we = 1'b0; cpu_burst = 1'b0; cpu_sel = 4'hF;
      cpu_req = 1'b1;
      @(posedge sd_clk);
      #1;
      checks++;
      if (mem_req !== 1'b1 || mem_adr !== 24'h000100) begin
         errors++;
         $display("FAIL single_issue got req=%b adr=%h exp req=1 adr=000100", mem_req, mem_adr);
      end
      for (int cyc = 0; cyc < 40 && got == 0; cyc++) begin
         @(posedge sd_clk);
         #1;
         if (cpu_ack) got = 1;
      end
      checks++;
      if (got != 1 || port_dat_o !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL single_data got ack=%0d dat=%h exp ack=1 dat=deadbeef", got, port_dat_o);
      end
      checks++;
      if (mem_req !== 1'b0) begin
         errors++;
         $display("FAIL single_req_drop got=%b exp=0", mem_req);
      end
      cpu_req = 1'b0;
      @(posedge sd_clk);
      #1;
      checks++;
      if (cpu_ack !== 1'b0) begin
         errors++;
         $display("FAIL single_one_ack got second ack=%b exp=0", cpu_ack);
      end
      fixed_lat = -1;
   endtask

   task automatic test_priority();
      int gv = 0, gs = 0, gc = 0, tv = 0, ts = 0, tc = 0;
      lat_max = 2;
      vid_adr = 24'h10_0040; snd_adr = 24'h20_0080; cpu_adr = 24'h30_00C0;
      cpu_we = 1'b0; cpu_burst = 1'b0;
      fork
         run_port(0, BURST_LEN, 200, gv, tv);
         run_port(1, BURST_LEN, 200, gs, ts);
         run_port(2, 1, 200, gc, tc);
      join
      checks++;
      if (gv != BURST_LEN || gs != BURST_LEN || gc != 1) begin
         errors++;
         $display("FAIL prio_counts got v=%0d s=%0d c=%0d exp 4/4/1", gv, gs, gc);
      end
      checks++;
      if (!(tv < ts && ts < tc)) begin
         errors++;
         $display("FAIL prio_order got end v=%0d s=%0d c=%0d exp v<s<c", tv, ts, tc);
      end
   endtask

   task automatic test_starvation();
      int vacks = 0, grant_at = -1;
      bit cdone = 1'b0;
      lat_max = 2;
      vid_adr = 24'h10_0000; cpu_adr = 24'hC0_1234; cpu_we = 1'b0; cpu_burst = 1'b0;
      vid_req = 1'b1;
      cpu_req = 1'b1;
      for (int cyc = 1; cyc < 400 && !cdone; cyc++) begin
         @(posedge sd_clk);
         #1;
         if (vid_ack) vacks++;
         if (grant_at < 0 && mem_req && !mem_burst) begin
            grant_at = cyc;
            checks++;
            if (dut.starve_cnt !== 8'd0) begin
               errors++;
               $display("FAIL starve_clear got=%0d exp=0", dut.starve_cnt);
            end
         end
         if (cpu_ack) cdone = 1'b1;
      end
      vid_req = 1'b0;
      cpu_req = 1'b0;
      checks++;
      if (!cdone) begin
         errors++;
         $display("FAIL starve_grant got no cpu ack exp cpu granted");
      end
      checks++;
      if (grant_at < STARVE_LIMIT + 1 || grant_at > STARVE_LIMIT + 18 || vacks < BURST_LEN) begin
         errors++;
         $display("FAIL starve_timing got grant_cycle=%0d vid_acks=%0d exp %0d..%0d and >=4",
                  grant_at, vacks, STARVE_LIMIT + 1, STARVE_LIMIT + 18);
      end
      repeat (20) @(posedge sd_clk);
      #1;
   endtask

   task automatic test_write_burst();
      int acks = 0;
      bit seen = 1'b0;
      cpu_adr = 24'h05_5554; cpu_we = 1'b1; cpu_burst = 1'b1; cpu_sel = 4'b0011;
      cpu_dat_i = 32'hA5A5_0F0F;
      cpu_req = 1'b1;
      for (int cyc = 0; cyc < 25; cyc++) begin
         @(posedge sd_clk);
         #1;
         if (mem_req && !seen) begin
            seen = 1'b1;
            checks++;
            if (mem_burst !== 1'b0 || mem_sel !== 4'b0011 || mem_we !== 1'b1 || mem_dat_o !== 32'hA5A5_0F0F) begin
               errors++;
               $display("FAIL write_fields got bu=%b sel=%b we=%b d=%h exp bu=0 sel=0011 we=1 d=a5a50f0f",
                        mem_burst, mem_sel, mem_we, mem_dat_o);
            end
         end
         if (cpu_ack) begin
            acks++;
            cpu_req = 1'b0;
         end
      end
      cpu_req = 1'b0;
      checks++;
      if (acks != 1) begin
         errors++;
         $display("FAIL write_acks got=%0d exp=1", acks);
      end
      cpu_we = 1'b0; cpu_burst = 1'b0; cpu_sel = 4'hF;
   endtask

   task automatic test_timeout();
      int hi = 0, got = 0, t = 0;
      bit done = 1'b0;
      no_ack = 1'b1;
      cpu_adr = 24'h00_0800; cpu_we = 1'b0; cpu_burst = 1'b0;
      cpu_req = 1'b1;
      for (int cyc = 0; cyc < 400 && !done; cyc++) begin
         @(posedge sd_clk);
         #1;
         if (mem_req) hi++;
         if (cpu_ack) begin
            done = 1'b1;
            checks++;
            if (cpu_err !== 1'b1 || port_dat_o !== 32'h0 || mem_req !== 1'b0) begin
               errors++;
               $display("FAIL timeout_abort got err=%b dat=%h req=%b exp err=1 dat=0 req=0",
                        cpu_err, port_dat_o, mem_req);
            end
         end
      end
      cpu_req = 1'b0;
      no_ack = 1'b0;
      checks++;
      if (!done || hi != TIMEOUT + 1) begin
         errors++;
         $display("FAIL timeout_len got done=%b req_cycles=%0d exp done=1 req_cycles=%0d", done, hi, TIMEOUT + 1);
      end
      @(posedge sd_clk);
      #1;
      run_port(2, 1, 50, got, t);
      checks++;
      if (got != 1) begin
         errors++;
         $display("FAIL timeout_recover got acks=%0d exp=1", got);
      end
   endtask

   task automatic test_random();
      int gv, gs, gc, tv, ts, tc, nc;
      bit uv, us, uc;
      lat_max = 4;
      for (int it = 0; it < 40; it++) begin
         uv = 1'($urandom); us = 1'($urandom); uc = 1'($urandom);
         if (!uv && !us && !uc) uc = 1'b1;
         vid_adr = 24'($urandom); snd_adr = 24'($urandom); cpu_adr = 24'($urandom);
         cpu_we = 1'($urandom); cpu_burst = 1'($urandom); cpu_sel = 4'($urandom);
         cpu_dat_i = $urandom;
         nc = (cpu_burst && !cpu_we) ? BURST_LEN : 1;
         gv = 0; gs = 0; gc = 0;
         fork
            begin if (uv) run_port(0, BURST_LEN, 300, gv, tv); end
            begin if (us) run_port(1, BURST_LEN, 300, gs, ts); end
            begin if (uc) run_port(2, nc, 300, gc, tc); end
         join
         checks++;
         if ((uv && gv != BURST_LEN) || (us && gs != BURST_LEN) || (uc && gc != nc)) begin
            errors++;
            $display("FAIL random_acks it=%0d got v=%0d s=%0d c=%0d exp v=%0d s=%0d c=%0d",
                     it, gv, gs, gc, uv ? BURST_LEN : 0, us ? BURST_LEN : 0, uc ? nc : 0);
         end
         repeat ($urandom_range(2, 0)) begin
            @(posedge sd_clk);
            #1;
         end
      end
   endtask

   task automatic test_reset_mid_burst();
      int acks = 0, got = 0, t = 0;
      lat_max = 2;
      vid_adr = 24'h0A_BCD0;
      vid_req = 1'b1;
      for (int cyc = 0; cyc < 60 && acks < 2; cyc++) begin
         @(posedge sd_clk);
         #1;
         if (vid_ack) acks++;
      end
      #1;
      sd_rst = 1'b1;
      vid_req = 1'b0;
      #1;
      checks++;
      if (acks != 2 || {vid_ack, snd_ack, cpu_ack, cpu_err, mem_req, mem_we, mem_burst} !== 7'b0 ||
          port_dat_o !== 32'h0 || {mem_adr, mem_sel, mem_dat_o} !== 60'h0) begin
         errors++;
         $display("FAIL rst_mid_outputs got acks=%0d req=%b ack=%b adr=%h dat=%h exp acks=2 all zero",
                  acks, mem_req, vid_ack, mem_adr, port_dat_o);
      end
      repeat (2) @(posedge sd_clk);
      #1;
      sd_rst = 1'b0;
      @(posedge sd_clk);
      #1;
      run_port(0, BURST_LEN, 100, got, t);
      checks++;
      if (got != BURST_LEN) begin
         errors++;
         $display("FAIL rst_mid_fresh got acks=%0d exp=%0d", got, BURST_LEN);
      end
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_priority();
      test_starvation();
      test_write_burst();
      test_timeout();
      test_random();
      test_reset_mid_burst();
      repeat (5) @(posedge sd_clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
